// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic bout;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/nibble_serial_subtractor_bla4.sv
// 4-bit borrow look-ahead slice: d4 = a4 - b4 - bin, with group P/G outputs.
module bla4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       bin,
  output logic [3:0] d4,
  output logic       bout,
  output logic       pg,
  output logic       gg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] brw;

  // Generate borrows where a=0,b=1; pass the incoming borrow where a==b.
  always_comb begin
    g      = ~a4 & b4;
    p      = ~(a4 ^ b4);
    brw[0] = bin;
    brw[1] = g[0] | (p[0] & bin);
    brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & bin);
    gg     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
    pg     = &p;
    brw[4] = gg | (pg & bin);
    d4     = a4 ^ b4 ^ brw[3:0];
    bout   = brw[4];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin, one nibble per clock, LSB nibble first.
//
//  state | meaning
//  IDLE  | ready for operands (in_ready=1)
//  RUN   | one nibble per cycle through the borrow slice
//  DONE  | result and flags held (out_valid=1) until out_ready
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = $clog2(NIB);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic               brw_q, brw_d;
  flags_t             flags_q, flags_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, d_nib;
  logic                s_bout, s_pg, s_gg;

  assign a_nib = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];

  bla4 u_bla4 (
    .a4   (a_nib),
    .b4   (b_nib),
    .bin  (brw_q),
    .d4   (d_nib),
    .bout (s_bout),
    .pg   (s_pg),
    .gg   (s_gg)
  );

  // State, counter, operand and result registers; reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic: accept, step one nibble per cycle, then hold the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[cnt_q*NIBBLE_W +: NIBBLE_W] = d_nib;
        brw_d = s_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NIB - 1)) begin
          // Group form gives the same final borrow as the slice's ripple output.
          flags_d.bout = s_gg | (s_pg & brw_q);
          flags_d.zero = (diff_d == '0);
          flags_d.neg  = diff_d[WIDTH-1];
          flags_d.ovf  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = flags_q.bout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomized self-checking bench against an arithmetic reference model.
module tb_nibble_serial_subtractor;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout, zero, neg, ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned and signed views.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ediff, output logic ebout, output logic ezero,
                       output logic eneg, output logic eovf);
    int ua, ub, r, sa, sb, sr;
    ua = int'(ma);
    ub = int'(mb);
    r  = ua - ub - int'(mbin);
    ediff = r[W-1:0];
    ebout = (r < 0);
    ezero = (ediff == '0);
    eneg  = ediff[W-1];
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    sr = sa - sb - int'(mbin);
    eovf = (sr > 32767) || (sr < -32768);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ed, input logic eb,
                              input logic ez, input logic en, input logic eo);
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".flags"}, {28'd0, bout, zero, neg, ovf}, {28'd0, eb, ez, en, eo});
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        input int hold, input bit pulse);
    logic [W-1:0] ed;
    logic eb, ez, en, eo;
    int lat;
    model(ta, tb_, tbin, ed, eb, ez, en, eo);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) begin
      chk("timeout", 32'(out_valid), 32'd1);
      return;
    end
    chk("latency", 32'(lat), 32'(NIB));
    check_result("res", ed, eb, ez, en, eo);
    for (int h = 0; h < hold; h++) begin
      if (pulse) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom); in_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      check_result("hold", ed, eb, ez, en, eo);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post.out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    check_result("rst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h5555, 16'h5554, 1'b1, 0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);

    // Backpressure with in_valid pulsing; the following op must be accepted right away.
    run_op(16'hA5A5, 16'h1234, 1'b1, 5, 1'b1);
    run_op(16'h0F0F, 16'hF0F0, 1'b0, 0, 1'b0);

    // Reset during RUN after nibble 1
    chk("in_ready_pre_rst", 32'(in_ready), 32'd1);
    a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    check_result("midrst", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);

    // Randomized operations with random backpressure
    for (int i = 0; i < 60; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
